// File: rtl/display_page_arbiter_if.sv
// Bus between the content generators, the display page arbiter and the
// digit-scan driver. The master side drives requests and content words;
// the slave side (the arbiter) returns grant, owner index and display word.
interface display_page_arbiter_if;
   logic [2:0]  req;
   logic [23:0] data0;
   logic [23:0] data1;
   logic [23:0] data2;
   logic [2:0]  gnt;
   logic [1:0]  src_id;
   logic [23:0] disp_data;
   logic        disp_update;

   modport master (
      output req, data0, data1, data2,
      input  gnt, src_id, disp_data, disp_update
   );

   modport slave (
      input  req, data0, data1, data2,
      output gnt, src_id, disp_data, disp_update
   );
endinterface

// File: rtl/display_page_arbiter.sv
// Display page arbiter: shares one 6-digit seven-segment display between a
// background source (0) and two requesting sources (1, 2). Enforces a minimum
// hold time, an ownership timeout with lockout, and priority between 1 and 2.
// Runs in the 1 kHz domain, one cycle = 1 ms.
// Optional build macro ROUND_ROBIN_EN: sources 1 and 2 share equal priority
// without preemption, alternating when both are eligible.
module display_page_arbiter #(
   parameter int HOLD_MS    = 1000,
   parameter int TIMEOUT_MS = 5000
) (
   input logic                    clk_1k,
   input logic                    rst_n,
   display_page_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(TIMEOUT_MS + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MS - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_MS - 1);
   localparam logic [CNT_W-1:0] TMO_MAX   = CNT_W'(TIMEOUT_MS);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

   typedef enum logic [1:0] {
      ST_BG   = 2'd0,
      ST_OWN1 = 2'd1,
      ST_OWN2 = 2'd2
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic [CNT_W-1:0] hold_cnt_r;
   logic [1:0]       lockout_r;     // [0] = source 1, [1] = source 2
   logic [1:0]       lock_set_s;
   logic             first_r;       // set until the first edge after reset
   logic             last_was1_r;   // source 1 was the most recent grant
   logic [2:0]       gnt_r;
   logic [1:0]       src_id_r;
   logic [23:0]      disp_data_r;
   logic             disp_update_r;
   logic [2:0]       gnt_nx_s;
   logic [1:0]       src_nx_s;
   logic [23:0]      data_nx_s;
   logic             elig1_s;
   logic             elig2_s;
   logic             hold_done_s;
   logic             tmo_s;
   logic             req0_unused_s;

   // Background source needs no request; its bit is deliberately ignored.
   assign req0_unused_s = bus.req[0];

   assign elig1_s     = bus.req[1] & ~lockout_r[0];
   assign elig2_s     = bus.req[2] & ~lockout_r[1];
   assign hold_done_s = (hold_cnt_r >= HOLD_LAST);
   assign tmo_s       = (hold_cnt_r >= TMO_LAST);

   // State register: ownership state, reset returns the display to background.
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_BG;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: priority, hold, timeout and lockout requests.
   always_comb begin
      next_state_s = state_r;
      lock_set_s   = 2'b00;
`ifdef ROUND_ROBIN_EN
      case (state_r)
         ST_BG: begin
            if (elig1_s && elig2_s) begin
               next_state_s = last_was1_r ? ST_OWN2 : ST_OWN1;
            end else if (elig2_s) begin
               next_state_s = ST_OWN2;
            end else if (elig1_s) begin
               next_state_s = ST_OWN1;
            end else begin
               next_state_s = ST_BG;
            end
         end
         ST_OWN1: begin
            if ((!bus.req[1] && hold_done_s) || (bus.req[1] && tmo_s)) begin
               lock_set_s[0] = bus.req[1];
               next_state_s  = elig2_s ? ST_OWN2 : ST_BG;
            end else begin
               next_state_s = ST_OWN1;
            end
         end
         ST_OWN2: begin
            if ((!bus.req[2] && hold_done_s) || (bus.req[2] && tmo_s)) begin
               lock_set_s[1] = bus.req[2];
               next_state_s  = elig1_s ? ST_OWN1 : ST_BG;
            end else begin
               next_state_s = ST_OWN2;
            end
         end
         default: begin
            next_state_s = ST_BG;
         end
      endcase
`else
      case (state_r)
         ST_BG: begin
            if (elig2_s) begin
               next_state_s = ST_OWN2;
            end else if (elig1_s) begin
               next_state_s = ST_OWN1;
            end else begin
               next_state_s = ST_BG;
            end
         end
         ST_OWN1: begin
            // Preemption is checked first so it wins over a coincident timeout.
            if (elig2_s) begin
               next_state_s = ST_OWN2;
            end else if (!bus.req[1] && hold_done_s) begin
               next_state_s = ST_BG;
            end else if (bus.req[1] && tmo_s) begin
               lock_set_s[0] = 1'b1;
               next_state_s  = ST_BG;
            end else begin
               next_state_s = ST_OWN1;
            end
         end
         ST_OWN2: begin
            if ((!bus.req[2] && hold_done_s) || (bus.req[2] && tmo_s)) begin
               lock_set_s[1] = bus.req[2];
               next_state_s  = elig1_s ? ST_OWN1 : ST_BG;
            end else begin
               next_state_s = ST_OWN2;
            end
         end
         default: begin
            next_state_s = ST_BG;
         end
      endcase
`endif
   end

   // Output decode: grant, index and display word of the next owner.
   always_comb begin
      gnt_nx_s  = 3'b001;
      src_nx_s  = 2'd0;
      data_nx_s = bus.data0;
      case (next_state_s)
         ST_OWN1: begin
            gnt_nx_s  = 3'b010;
            src_nx_s  = 2'd1;
            data_nx_s = bus.data1;
         end
         ST_OWN2: begin
            gnt_nx_s  = 3'b100;
            src_nx_s  = 2'd2;
            data_nx_s = bus.data2;
         end
         default: begin
            gnt_nx_s  = 3'b001;
            src_nx_s  = 2'd0;
            data_nx_s = bus.data0;
         end
      endcase
   end

   // Registered outputs; the update pulse also fires once after reset release.
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         gnt_r         <= 3'b001;
         src_id_r      <= 2'd0;
         disp_data_r   <= 24'h000000;
         disp_update_r <= 1'b0;
         first_r       <= 1'b1;
      end else begin
         gnt_r         <= gnt_nx_s;
         src_id_r      <= src_nx_s;
         disp_data_r   <= data_nx_s;
         disp_update_r <= first_r | (next_state_s != state_r);
         first_r       <= 1'b0;
      end
   end

   // Hold counter: cleared on a new grant, saturating count while owned.
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_r <= CNT_ZERO;
      end else if ((next_state_s != state_r) || (state_r == ST_BG)) begin
         hold_cnt_r <= CNT_ZERO;
      end else if (hold_cnt_r < TMO_MAX) begin
         hold_cnt_r <= hold_cnt_r + CNT_ONE;
      end else begin
         hold_cnt_r <= hold_cnt_r;
      end
   end

   // Lockout: set on timeout, cleared as soon as the source drops its request.
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         lockout_r <= 2'b00;
      end else begin
         lockout_r <= lock_set_s | (lockout_r & bus.req[2:1]);
      end
   end

   // Most-recent-grant tracker for alternating between sources 1 and 2.
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         last_was1_r <= 1'b0;
      end else if ((next_state_s == ST_OWN1) && (state_r != ST_OWN1)) begin
         last_was1_r <= 1'b1;
      end else if ((next_state_s == ST_OWN2) && (state_r != ST_OWN2)) begin
         last_was1_r <= 1'b0;
      end else begin
         last_was1_r <= last_was1_r;
      end
   end

   assign bus.gnt         = gnt_r;
   assign bus.src_id      = src_id_r;
   assign bus.disp_data   = disp_data_r;
   assign bus.disp_update = disp_update_r;

endmodule

// File: tb/tb_display_page_arbiter.sv
// Directed self-checking bench for display_page_arbiter with HOLD_MS=4,
// TIMEOUT_MS=20. Inputs change and outputs are sampled 1 time unit after
// each rising clock edge.
module tb_display_page_arbiter;

   logic clk_1k = 1'b0;
   logic rst_n  = 1'b0;
   int   total  = 0;
   int   bad    = 0;

   display_page_arbiter_if bus ();

   display_page_arbiter #(.HOLD_MS(4), .TIMEOUT_MS(20)) dut (
      .clk_1k (clk_1k),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 clk_1k = ~clk_1k;

   task automatic tick();
      @(posedge clk_1k);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      bus.req = 3'b000; bus.data0 = 24'h123456;
      bus.data1 = 24'h000042; bus.data2 = 24'h999999;
      rst_n = 1'b0;
      #12;
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL reset_gnt got=%b want=001", bus.gnt); end
      total++; if (bus.disp_data !== 24'h000000) begin bad++; $display("FAIL reset_data got=%h want=000000", bus.disp_data); end
      total++; if (bus.disp_update !== 1'b0) begin bad++; $display("FAIL reset_upd got=%b want=0", bus.disp_update); end
      tick();
      rst_n = 1'b1;
      tick();
      total++; if (bus.disp_update !== 1'b1) begin bad++; $display("FAIL first_upd got=%b want=1", bus.disp_update); end
      total++; if (bus.disp_data !== 24'h123456) begin bad++; $display("FAIL idle_data got=%h want=123456", bus.disp_data); end
      total++; if (bus.gnt !== 3'b001 || bus.src_id !== 2'd0) begin bad++; $display("FAIL idle_gnt got=%b/%0d want=001/0", bus.gnt, bus.src_id); end
      tick();
      total++; if (bus.disp_update !== 1'b0) begin bad++; $display("FAIL idle_upd got=%b want=0", bus.disp_update); end
   endtask

   task automatic test_short_request();
      bus.data1 = 24'h000042;
      bus.req = 3'b010;
      tick();
      total++; if (bus.gnt !== 3'b010 || bus.src_id !== 2'd1) begin bad++; $display("FAIL short_gnt got=%b/%0d want=010/1", bus.gnt, bus.src_id); end
      total++; if (bus.disp_update !== 1'b1 || bus.disp_data !== 24'h000042) begin bad++; $display("FAIL short_upd got=%b/%h want=1/000042", bus.disp_update, bus.disp_data); end
      tick();
      bus.req = 3'b000;
      tick();
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL short_hold got=%b want=010", bus.gnt); end
      bus.data1 = 24'h000077;
      tick();
      total++; if (bus.gnt !== 3'b010 || bus.disp_data !== 24'h000077) begin bad++; $display("FAIL short_live got=%b/%h want=010/000077", bus.gnt, bus.disp_data); end
      tick();
      total++; if (bus.gnt !== 3'b001 || bus.disp_update !== 1'b1) begin bad++; $display("FAIL short_release got=%b/%b want=001/1", bus.gnt, bus.disp_update); end
      total++; if (bus.disp_data !== 24'h123456) begin bad++; $display("FAIL short_bgdata got=%h want=123456", bus.disp_data); end
   endtask

   task automatic test_preemption();
      bus.data1 = 24'h000042;
      bus.req = 3'b010;
      tick();
      tick();
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL pre_own1 got=%b want=010", bus.gnt); end
      bus.data2 = 24'h999999;
      bus.req = 3'b110;
      tick();
`ifdef ROUND_ROBIN_EN
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL pre_none got=%b want=010", bus.gnt); end
      bus.req = 3'b000;
      ticks(4);
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL pre_bg got=%b want=001", bus.gnt); end
`else
      total++; if (bus.gnt !== 3'b100 || bus.disp_data !== 24'h999999) begin bad++; $display("FAIL pre_gnt got=%b/%h want=100/999999", bus.gnt, bus.disp_data); end
      total++; if (bus.disp_update !== 1'b1) begin bad++; $display("FAIL pre_upd got=%b want=1", bus.disp_update); end
      bus.req = 3'b010;
      ticks(3);
      total++; if (bus.gnt !== 3'b100) begin bad++; $display("FAIL pre_hold2 got=%b want=100", bus.gnt); end
      tick();
      total++; if (bus.gnt !== 3'b010 || bus.disp_data !== 24'h000042) begin bad++; $display("FAIL pre_back1 got=%b/%h want=010/000042", bus.gnt, bus.disp_data); end
      bus.req = 3'b000;
      ticks(4);
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL pre_bg got=%b want=001", bus.gnt); end
`endif
   endtask

   task automatic test_timeout();
      bus.req = 3'b010;
      tick();
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL tmo_grant got=%b want=010", bus.gnt); end
      ticks(19);
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL tmo_last got=%b want=010", bus.gnt); end
      tick();
      total++; if (bus.gnt !== 3'b001 || bus.disp_update !== 1'b1) begin bad++; $display("FAIL tmo_forced got=%b/%b want=001/1", bus.gnt, bus.disp_update); end
      ticks(10);
      total++; if (bus.gnt !== 3'b001 || bus.disp_update !== 1'b0) begin bad++; $display("FAIL tmo_lockout got=%b/%b want=001/0", bus.gnt, bus.disp_update); end
      bus.req = 3'b000;
      tick();
      bus.req = 3'b010;
      tick();
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("FAIL tmo_regrant got=%b want=010", bus.gnt); end
      bus.req = 3'b000;
      ticks(4);
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL tmo_bg got=%b want=001", bus.gnt); end
   endtask

   task automatic test_simultaneous();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      bus.req = 3'b110;
      tick();
`ifdef ROUND_ROBIN_EN
      total++; if (bus.gnt !== 3'b010 || bus.src_id !== 2'd1) begin bad++; $display("FAIL sim_gnt got=%b/%0d want=010/1", bus.gnt, bus.src_id); end
`else
      total++; if (bus.gnt !== 3'b100 || bus.src_id !== 2'd2) begin bad++; $display("FAIL sim_gnt got=%b/%0d want=100/2", bus.gnt, bus.src_id); end
`endif
      bus.req = 3'b000;
      ticks(4);
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("FAIL sim_bg got=%b want=001", bus.gnt); end
   endtask

   task automatic test_async_reset();
      bus.data2 = 24'hABCDEF;
      bus.req = 3'b100;
      tick();
      total++; if (bus.gnt !== 3'b100 || bus.disp_data !== 24'hABCDEF) begin bad++; $display("FAIL ar_own2 got=%b/%h want=100/abcdef", bus.gnt, bus.disp_data); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus.gnt !== 3'b001 || bus.src_id !== 2'd0) begin bad++; $display("FAIL ar_gnt got=%b/%0d want=001/0", bus.gnt, bus.src_id); end
      total++; if (bus.disp_data !== 24'h000000) begin bad++; $display("FAIL ar_data got=%h want=000000", bus.disp_data); end
      bus.req = 3'b000;
      tick();
      rst_n = 1'b1;
      tick();
      total++; if (bus.gnt !== 3'b001 || bus.disp_data !== 24'h123456) begin bad++; $display("FAIL ar_after got=%b/%h want=001/123456", bus.gnt, bus.disp_data); end
   endtask

   initial begin
      test_reset();
      test_short_request();
      test_preemption();
      test_timeout();
      test_simultaneous();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
